bcd_scan_driver: RTL
====================

# bcd_scan_driver

Four-digit multiplexed seven-segment driver that consumes the BCD digit buses produced by the stopwatch counter (seconds low/high, minutes low/high) and scans them onto a common-anode display. Snapshots the digits once per frame to prevent tearing, decodes BCD to segments, inserts an anti-ghosting guard interval, and supports per-digit blinking (adjust mode) and minute-tens leading-zero suppression. Sits between the counter and the board pins, clocked by the fast system clock.

## Interface

- REFRESH_DIV, 100000: system clocks per digit slot (≥ GUARD+2).
- GUARD, 2000: clocks at the start of each slot with all anodes off (< REFRESH_DIV).
- BLINK_TICKS, 250: slot ticks per blink half-period (≥1).

- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- digit_0  in  4  seconds-low BCD, displayed on slot 0 (rightmost).
- digit_1  in  4  seconds-high BCD, slot 1.
- digit_2  in  4  minutes-low BCD, slot 2.
- digit_3  in  4  minutes-high BCD, slot 3 (leftmost).
- dp  in  4  decimal-point request per slot, active-high.
- blink_mask  in  4  per-slot blink enable, active-high.
- lz_en  in  1  blank slot 3 when its snapshot is 0.
- an  out  4  anode enables, active-low, bit n = slot n.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.

## Operation

- Refresh counter cnt, width clog2(REFRESH_DIV): counts 0..REFRESH_DIV-1, wraps to 0. tick = (cnt == REFRESH_DIV-1).
- Slot register s (2 bits): advances 0→1→2→3→0 on tick.
- Snapshot: on the tick where s goes 3→0, snap0..snap3 <= digit_0..digit_3 and snap_dp <= dp, so a new frame shows the new values starting at slot 0. Inputs changing mid-frame never affect the current frame.
- Blink: tick counter counts 0..BLINK_TICKS-1; on its wrap, blink_phase toggles.
- Digit visible when all of: cnt ≥ GUARD; not (blink_phase=1 and blink_mask[s]=1); not (s=3 and lz_en=1 and snap3=0). blink_mask and lz_en are sampled live, not snapshotted.
- Visible: an = one-cold on bit s; seg = decode(snap[s]); dp_n = ~snap_dp[s]. Not visible: an=4'b1111, seg=7'b1111111, dp_n=1.
- Decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 10–15 = 1111111 (blank segments; anode still enabled, dp still honoured).

## Timing

- an, seg, dp_n are registered: each reflects cnt/s/blink_phase/snap state of the previous clock (1-cycle latency). Never more than one anode low in any cycle.
- Reset (rst=0, async): cnt=0, s=0, blink counter=0, blink_phase=0, snap0..3=0, snap_dp=0; an=4'b1111, seg=7'b1111111, dp_n=1 immediately. First frame after reset shows 0000 (or blank slot 3 if lz_en), then live values from the second frame.
- Reset release: cnt starts counting on the first rising edge with rst=1; slot 0 anode first goes low at clock GUARD+1 after release.
- Frame period 4·REFRESH_DIV clocks; each slot lit for REFRESH_DIV-GUARD clocks.
- Reset asserted mid-slot: outputs blank in the same cycle, independent of clk; scan restarts from slot 0.
- Snapshot and slot wrap occur on the same edge; tick into slot 0 and a blink-phase toggle on the same edge both take effect together.

## Test plan

- Reset: hold rst=0 with digits 4'h5 -> an=1111, seg=1111111, dp_n=1; release, REFRESH_DIV=8, GUARD=2 -> an=1110 first at clock 3, seg=1000000 (snapshot 0).
- Decode sweep (REFRESH_DIV=8, GUARD=2): digit_0 = 0..9 across frames -> seg in slot 0 matches table; digit_0=4'hC -> seg=1111111 with an=1110.
- Scan/guard: digits 1,2,3,4 -> an sequence 1110,1101,1011,0111 each for 6 clocks separated by 2 clocks of 1111; seg 1111001,0100100,0110000,0011001.
- Tearing: change digit_0 5→6 while s=2 -> slot 0 of next frame shows 6, current frame slots 2/3 unchanged; change during slot 0 -> not shown until next frame.
- Blink/lz: BLINK_TICKS=4, blink_mask=0011 -> slots 0,1 anodes stay 1111 for 4 ticks every 8; lz_en=1, digit_3=0 -> slot 3 always 1111; digit_3=5 -> slot 3 shows 0010010.
- Async reset mid-slot 2 with dp=0100 -> outputs blank without clock edge; after release, scan resumes at slot 0, dp_n=1 until snapshot captures dp.

Source files
------------

// File: rtl/bcd_scan_if.sv
// Digit buses from the stopwatch counter in, multiplexed display pins out.
interface bcd_scan_if;
    logic [3:0] digit_0;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [3:0] digit_3;
    logic [3:0] dp;
    logic [3:0] blink_mask;
    logic       lz_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;

    // Counter side: drives the digits and display controls, sees the pins.
    modport master (
        output digit_0, digit_1, digit_2, digit_3, dp, blink_mask, lz_en,
        input  an, seg, dp_n
    );

    // Scan driver side.
    modport slave (
        input  digit_0, digit_1, digit_2, digit_3, dp, blink_mask, lz_en,
        output an, seg, dp_n
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver for a common-anode display.
// The digits are captured once per frame so that a counter update never
// tears a frame. Each slot starts with a guard gap, with all anodes off,
// to suppress ghosting. Slots can blink, and minute tens can be blanked
// when they are zero.
module bcd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2000,
    parameter int BLINK_TICKS = 250
) (
    input  logic      clk,
    input  logic      rst,
    bcd_scan_if.slave bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          slot_q, slot_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [3:0][3:0]     snap_q, snap_d;
    logic [3:0]          snap_dp_q, snap_dp_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;

    logic                tick;
    logic                visible;
    logic [3:0]          cur_digit;

    // BCD to active-low {g,f,e,d,c,b,a}; codes 10-15 show no segments.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Refresh timing, slot sequencing, blink timebase and frame snapshot.
    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        slot_d    = tick ? slot_q + 2'd1 : slot_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
            // Capture on the same edge that wraps back to slot 0, so the new
            // frame starts with the new values.
            if (slot_q == 2'd3) begin
                snap_d    = {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0};
                snap_dp_d = bus.dp;
            end
        end
    end

    // Output selection for the current slot; blink and blanking controls are live.
    always_comb begin
        cur_digit = snap_q[slot_q];
        visible   = (cnt_q >= GUARD_C)
                    && !(phase_q && bus.blink_mask[slot_q])
                    && !((slot_q == 2'd3) && bus.lz_en && (snap_q[3] == 4'd0));
        an_d      = 4'b1111;
        seg_d     = 7'b1111111;
        dp_n_d    = 1'b1;
        if (visible) begin
            an_d   = ~(4'b0001 << slot_q);
            seg_d  = decode(cur_digit);
            dp_n_d = ~snap_dp_q[slot_q];
        end
    end

    // State and registered pin outputs; reset blanks the pins immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            slot_q    <= 2'd0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            snap_q    <= '0;
            snap_dp_q <= 4'd0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_n_q    <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp_n = dp_n_q;

endmodule
